// File: rtl/dmem_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Request: dreq/daddr/dwdata/we. Response: dready/drdata/derr.
interface dmem_if;
    logic        dreq;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic        dready;
    logic [31:0] drdata;
    logic        derr;

    modport master (
        output dreq, daddr, dwdata, we,
        input  dready, drdata, derr
    );

    modport slave (
        input  dreq, daddr, dwdata, we,
        output dready, drdata, derr
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory.
// Byte-masked write / word read, dready pulse.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ?
    4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_we;
  logic [31:0]       r_drdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_go;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_in_idx;
  logic              w_in_oob;
  logic [ADDR_W-1:0] w_acc_idx;
  logic [31:0]       w_acc_wdata;
  logic [3:0]        w_acc_we;
  logic              w_acc_oob;
  logic              w_unused;

  assign w_accept = bus.dreq &&
                    (r_state != S_WAIT);
  assign w_in_idx = bus.daddr[ADDR_W+1:2];

`ifdef DMEM_BOUNDS_EN
  logic r_oob;
  logic r_derr;

  assign w_in_oob =
    |bus.daddr[31:ADDR_W+2];
  assign w_unused =
    &{1'b0, bus.daddr[1:0]};
  assign bus.derr = r_derr;
`else
  assign w_in_oob = 1'b0;
  assign w_unused =
    &{1'b0, bus.daddr[1:0],
      bus.daddr[31:ADDR_W+2]};
  assign bus.derr = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_acc_idx   = w_in_idx;
    w_acc_wdata = bus.dwdata;
    w_acc_we    = bus.we;
    w_acc_oob   = w_in_oob;
    if (r_state == S_WAIT) begin
      w_acc_idx   = r_idx;
      w_acc_wdata = r_wdata;
      w_acc_we    = r_we;
`ifdef DMEM_BOUNDS_EN
      w_acc_oob   = r_oob;
`endif
    end
  end

  assign w_go    = (w_state_nxt == S_DONE) &&
                   rst_n;
  assign w_wr_en = w_go && !w_acc_oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_wdata  <= 32'd0;
      r_we     <= 4'd0;
      r_drdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= w_in_idx;
        r_wdata <= bus.dwdata;
        r_we    <= bus.we;
      end
      if (w_go) begin
        if (w_acc_oob) begin
          r_drdata <= 32'hDEAD_BEEF;
        end else if (w_acc_we == 4'd0) begin
          r_drdata <= r_mem[w_acc_idx];
        end
      end
    end
  end

`ifdef DMEM_BOUNDS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oob  <= 1'b0;
      r_derr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_oob <= w_in_oob;
      end
      r_derr <= w_go && w_acc_oob;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_we[i]) begin
          r_mem[w_acc_idx][8*i +: 8] <=
            w_acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.dready = (r_state == S_DONE);
  assign bus.drdata = r_drdata;

endmodule
